// File: rtl/palette_fifo_scheduler.sv
`timescale 1ns/1ps
// palette_fifo_scheduler: single-port 256x24 palette RAM shared between pixel
// index lookups and CPU palette writes; lookups are throttled on FIFO occupancy.
module palette_fifo_scheduler #(
  parameter int FIFO_SIZE_BITS = 8,
  parameter int FIFO_LIMIT     = 6,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic [7:0]                pix_index,
  output logic                      pix_ready,
  input  logic                      cpu_valid,
  input  logic [7:0]                cpu_addr,
  input  logic [23:0]               cpu_color,
  output logic                      cpu_ready,
  input  logic                      vblank,
  input  logic [FIFO_SIZE_BITS-1:0] fifo_size,
  input  logic                      fifo_full,
  output logic                      fifo_write_en,
  output logic [23:0]               fifo_data
);

  localparam int OCC_W = FIFO_SIZE_BITS + 1;
  localparam logic [OCC_W-1:0] OCC_LIMIT     = OCC_W'(FIFO_LIMIT);
  localparam logic [3:0]       STARVE_THRESH = 4'(STARVE_LIMIT);
  localparam logic [3:0]       STARVE_MAX    = 4'hF;

  logic             inflight;
  logic [3:0]       starve_cnt;
  logic [OCC_W-1:0] occupancy;
  logic             pix_eligible;
  logic             starve_hit;
  logic             pix_xfer;
  logic             cpu_xfer;
  logic [23:0]      read_data;
  logic [23:0]      palette_mem [0:255];

  // Occupancy is widened by one bit so a full-scale fifo_size plus an
  // in-flight lookup cannot wrap back into the eligible range.
  assign occupancy    = {1'b0, fifo_size} + {{FIFO_SIZE_BITS{1'b0}}, inflight};
  assign pix_eligible = !fifo_full && (occupancy < OCC_LIMIT);
  assign starve_hit   = (starve_cnt >= STARVE_THRESH);

  always_comb begin
    pix_ready = 1'b0;
    cpu_ready = 1'b0;
    if (vblank) begin
      cpu_ready = 1'b1;
    end else if (starve_hit && cpu_valid) begin
      cpu_ready = 1'b1;
    end else if (pix_eligible && pix_valid) begin
      pix_ready = 1'b1;
    end else begin
      cpu_ready = 1'b1;
      pix_ready = pix_eligible;
    end
  end

  assign pix_xfer = pix_valid && pix_ready;
  assign cpu_xfer = cpu_valid && cpu_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight   <= 1'b0;
      starve_cnt <= 4'd0;
    end else begin
      inflight <= pix_xfer;
      if (cpu_xfer) begin
        starve_cnt <= 4'd0;
      end else if (cpu_valid && (starve_cnt != STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Palette contents survive reset; the arbiter guarantees at most one of
  // the write and the read below is active in any cycle.
  always_ff @(posedge clk) begin
    if (cpu_xfer) begin
      palette_mem[cpu_addr] <= cpu_color;
    end
    if (pix_xfer) begin
      read_data <= palette_mem[pix_index];
    end
  end

  assign fifo_write_en = inflight;
  assign fifo_data     = inflight ? read_data : 24'h0;

endmodule

// File: tb/tb_palette_fifo_scheduler.sv
`timescale 1ns/1ps
// Bench for palette_fifo_scheduler: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbiter and palette contents.
module tb_palette_fifo_scheduler;

  localparam int FIFO_SIZE_BITS = 8;
  localparam int FIFO_LIMIT     = 6;
  localparam int STARVE_LIMIT   = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      pix_valid;
  logic [7:0]                pix_index;
  logic                      pix_ready;
  logic                      cpu_valid;
  logic [7:0]                cpu_addr;
  logic [23:0]               cpu_color;
  logic                      cpu_ready;
  logic                      vblank;
  logic [FIFO_SIZE_BITS-1:0] fifo_size;
  logic                      fifo_full;
  logic                      fifo_write_en;
  logic [23:0]               fifo_data;

  always #5 clk = ~clk;

  palette_fifo_scheduler #(
    .FIFO_SIZE_BITS(FIFO_SIZE_BITS),
    .FIFO_LIMIT    (FIFO_LIMIT),
    .STARVE_LIMIT  (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pix_valid    (pix_valid),
    .pix_index    (pix_index),
    .pix_ready    (pix_ready),
    .cpu_valid    (cpu_valid),
    .cpu_addr     (cpu_addr),
    .cpu_color    (cpu_color),
    .cpu_ready    (cpu_ready),
    .vblank       (vblank),
    .fifo_size    (fifo_size),
    .fifo_full    (fifo_full),
    .fifo_write_en(fifo_write_en),
    .fifo_data    (fifo_data)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: palette contents, starvation count, lookup in flight.
  logic [23:0] m_pal [256];
  int          m_starve;
  bit          m_inflight;
  bit          e_pr, e_cr, e_we;
  logic [23:0] e_data;
  logic        s_pr, s_cr;

  task automatic set_idle();
    pix_valid = 1'b0;
    pix_index = 8'h00;
    cpu_valid = 1'b0;
    cpu_addr  = 8'h00;
    cpu_color = 24'h0;
    vblank    = 1'b0;
    fifo_size = '0;
    fifo_full = 1'b0;
  endtask

  // One clock: starts just after a negedge with inputs applied, predicts the
  // grants, samples the DUT readies, applies the transfers to the model at the
  // edge and returns on the following negedge with FIFO expectations ready.
  task automatic cycle();
    int occ;
    bit elig, pxf, cxf;
    #1;
    occ  = int'(fifo_size) + (m_inflight ? 1 : 0);
    elig = !fifo_full && (occ < FIFO_LIMIT);
    if (vblank) begin
      e_cr = 1'b1; e_pr = 1'b0;
    end else if (m_starve >= STARVE_LIMIT && cpu_valid) begin
      e_cr = 1'b1; e_pr = 1'b0;
    end else if (elig && pix_valid) begin
      e_pr = 1'b1; e_cr = 1'b0;
    end else begin
      e_cr = 1'b1; e_pr = elig;
    end
    s_pr = pix_ready;
    s_cr = cpu_ready;
    @(posedge clk);
    pxf    = pix_valid && e_pr;
    cxf    = cpu_valid && e_cr;
    e_we   = pxf;
    e_data = pxf ? m_pal[pix_index] : 24'h0;
    if (cxf) begin
      m_pal[cpu_addr] = cpu_color;
      m_starve = 0;
    end else if (cpu_valid && m_starve < 15) begin
      m_starve++;
    end
    m_inflight = pxf;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    m_starve   = 0;
    m_inflight = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (fifo_write_en !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_write_en: got %b expected 0", fifo_write_en);
    end
    tests_run++;
    if (fifo_data !== 24'h0) begin
      tests_failed++; $display("[TB] FAIL reset_data: got %h expected 000000", fifo_data);
    end
    tests_run++;
    if (pix_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_pix_ready: got %b expected 1", pix_ready);
    end
    tests_run++;
    if (cpu_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL reset_cpu_ready: got %b expected 1", cpu_ready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic preload_palette();
    set_idle();
    vblank    = 1'b1;
    cpu_valid = 1'b1;
    for (int a = 0; a < 256; a++) begin
      cpu_addr  = 8'(a);
      cpu_color = 24'($urandom);
      cycle();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_lookup();
    set_idle();
    pix_valid = 1'b1;
    cpu_valid = 1'b1;
    cpu_addr  = 8'h20;
    cpu_color = 24'($urandom);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      pix_index = 8'($urandom);
      cycle();
    end
    cpu_valid = 1'b0;
    pix_index = 8'h33;
    #1;
    tests_run++;
    if (pix_ready !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL midreset_pix_ready: got %b expected 1", pix_ready);
    end
    @(posedge clk);
    #2;
    reset      = 1'b1;
    pix_valid  = 1'b0;
    m_starve   = 0;
    m_inflight = 1'b0;
    @(negedge clk);
    tests_run++;
    if (fifo_write_en !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL midreset_dropped: got %b expected 0", fifo_write_en);
    end
    tests_run++;
    if (fifo_data !== 24'h0) begin
      tests_failed++; $display("[TB] FAIL midreset_data: got %h expected 000000", fifo_data);
    end
    @(negedge clk);
    reset     = 1'b0;
    pix_valid = 1'b1;
    cpu_valid = 1'b1;
    cycle();
    tests_run++;
    if (s_pr !== 1'b1 || s_cr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_starve_cleared: got pix=%b cpu=%b expected pix=1 cpu=0", s_pr, s_cr);
    end
    set_idle();
    cycle();
  endtask

  task automatic test_write_lookup();
    set_idle();
    cpu_valid = 1'b1;
    cpu_addr  = 8'h10;
    cpu_color = 24'hAABBCC;
    cycle();
    tests_run++;
    if (s_cr !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL wl_cpu_ready: got %b expected 1", s_cr);
    end
    cpu_valid = 1'b0;
    pix_valid = 1'b1;
    pix_index = 8'h10;
    cycle();
    tests_run++;
    if (s_pr !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL wl_pix_ready: got %b expected 1", s_pr);
    end
    tests_run++;
    if (fifo_write_en !== 1'b1 || fifo_data !== 24'hAABBCC) begin
      tests_failed++;
      $display("[TB] FAIL wl_lookup: got we=%b data=%h expected we=1 data=aabbcc", fifo_write_en, fifo_data);
    end
    pix_valid = 1'b0;
    cycle();
    tests_run++;
    if (fifo_write_en !== 1'b0 || fifo_data !== 24'h0) begin
      tests_failed++;
      $display("[TB] FAIL wl_single_pulse: got we=%b data=%h expected we=0 data=000000", fifo_write_en, fifo_data);
    end
  endtask

  task automatic test_streaming();
    set_idle();
    for (int i = 0; i < 20; i++) begin
      pix_valid = 1'b1;
      pix_index = 8'(i);
      cycle();
      tests_run++;
      if (s_pr !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", i, s_pr);
      end
      tests_run++;
      if (fifo_write_en !== 1'b1 || fifo_data !== m_pal[i]) begin
        tests_failed++;
        $display("[TB] FAIL stream_data[%0d]: got we=%b data=%h expected we=1 data=%h", i, fifo_write_en, fifo_data, m_pal[i]);
      end
    end
    set_idle();
    cycle();
  endtask

  task automatic test_throttle();
    bit pre       [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int sizes     [7] = '{5, 5, 4, 6, 0, 0, 255};
    bit full      [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bit exp_ready [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int r = 0; r < 7; r++) begin
      set_idle();
      pix_valid = pre[r];
      pix_index = 8'(r);
      cycle();
      fifo_size = 8'(sizes[r]);
      fifo_full = full[r];
      pix_valid = 1'b1;
      #1;
      tests_run++;
      if (pix_ready !== exp_ready[r]) begin
        tests_failed++;
        $display("[TB] FAIL throttle[%0d] size=%0d full=%b inflight=%b: got %b expected %b",
                 r, sizes[r], full[r], pre[r], pix_ready, exp_ready[r]);
      end
    end
    set_idle();
    cycle();
  endtask

  task automatic test_starvation();
    set_idle();
    cpu_valid = 1'b1;
    cpu_addr  = 8'($urandom);
    cpu_color = 24'($urandom);
    cycle();
    pix_valid = 1'b1;
    pix_index = 8'($urandom);
    cpu_addr  = 8'($urandom);
    cpu_color = 24'($urandom);
    for (int i = 0; i < 15; i++) begin
      cycle();
      tests_run++;
      if (s_pr !== (i % 5 != 4) || s_cr !== (i % 5 == 4)) begin
        tests_failed++;
        $display("[TB] FAIL starve_pattern[%0d]: got pix=%b cpu=%b expected pix=%b cpu=%b",
                 i, s_pr, s_cr, (i % 5 != 4), (i % 5 == 4));
      end
      if (e_pr) pix_index = 8'($urandom);
      if (e_cr) begin
        cpu_addr  = 8'($urandom);
        cpu_color = 24'($urandom);
      end
    end
    set_idle();
    cycle();
  endtask

  task automatic test_vblank();
    set_idle();
    vblank    = 1'b1;
    pix_valid = 1'b1;
    cpu_valid = 1'b1;
    pix_index = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      cpu_addr  = 8'($urandom);
      cpu_color = 24'($urandom);
      cycle();
      tests_run++;
      if (s_cr !== 1'b1 || s_pr !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL vblank_prio[%0d]: got pix=%b cpu=%b expected pix=0 cpu=1", i, s_pr, s_cr);
      end
    end
    vblank = 1'b0;
    cycle();
    tests_run++;
    if (s_pr !== 1'b1 || s_cr !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL vblank_release: got pix=%b cpu=%b expected pix=1 cpu=0", s_pr, s_cr);
    end
    set_idle();
    cycle();
  endtask

  task automatic test_no_pixel();
    set_idle();
    cpu_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fifo_full = (i % 2 == 1);
      cpu_addr  = 8'($urandom);
      cpu_color = 24'($urandom);
      cycle();
      tests_run++;
      if (s_cr !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL nopix_cpu_ready[%0d]: got %b expected 1", i, s_cr);
      end
    end
    fifo_full = 1'b0;
    pix_valid = 1'b1;
    pix_index = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      cycle();
      tests_run++;
      if (s_pr !== (i < 4) || s_cr !== (i == 4)) begin
        tests_failed++;
        $display("[TB] FAIL nopix_starve_zero[%0d]: got pix=%b cpu=%b expected pix=%b cpu=%b",
                 i, s_pr, s_cr, (i < 4), (i == 4));
      end
      if (e_pr) pix_index = 8'($urandom);
    end
    set_idle();
    cycle();
  endtask

  task automatic test_random();
    bit pix_hold = 1'b0;
    bit cpu_hold = 1'b0;
    set_idle();
    for (int n = 0; n < 500; n++) begin
      if (!pix_hold) begin
        pix_valid = ($urandom_range(0, 3) != 0);
        pix_index = 8'($urandom);
      end
      if (!cpu_hold) begin
        cpu_valid = ($urandom_range(0, 2) == 0);
        cpu_addr  = 8'($urandom);
        cpu_color = 24'($urandom);
      end
      vblank    = ($urandom_range(0, 15) == 0);
      fifo_full = ($urandom_range(0, 9) == 0);
      fifo_size = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 6));
      cycle();
      tests_run++;
      if (s_pr !== e_pr) begin
        tests_failed++; $display("[TB] FAIL rnd_pix_ready[%0d]: got %b expected %b", n, s_pr, e_pr);
      end
      tests_run++;
      if (s_cr !== e_cr) begin
        tests_failed++; $display("[TB] FAIL rnd_cpu_ready[%0d]: got %b expected %b", n, s_cr, e_cr);
      end
      tests_run++;
      if (fifo_write_en !== e_we) begin
        tests_failed++; $display("[TB] FAIL rnd_write_en[%0d]: got %b expected %b", n, fifo_write_en, e_we);
      end
      tests_run++;
      if (fifo_data !== e_data) begin
        tests_failed++; $display("[TB] FAIL rnd_data[%0d]: got %h expected %h", n, fifo_data, e_data);
      end
      pix_hold = pix_valid && !e_pr;
      cpu_hold = cpu_valid && !e_cr;
    end
    set_idle();
    cycle();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) m_pal[a] = 24'h0;
    test_reset();
    preload_palette();
    test_reset_mid_lookup();
    test_write_lookup();
    test_streaming();
    test_throttle();
    test_starvation();
    test_vblank();
    test_no_pixel();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
